register_serializer: RTL and testbench
======================================

# register_serializer

Parallel-in/serial-out companion to the `register` block: accepts one WIDTH-bit word (typically a `reg_out` value) on a load handshake and shifts it out one bit per clock with a bit-valid strobe. It sits on the read side of the datapath registers and exports register contents over a single-bit link. At the end of each word it raises a one-cycle done pulse. It accepts back-to-back words with no idle gap.

## Interface
- `WIDTH`, 11: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `ser_in` input WIDTH: parallel word to transmit.
- `ser_load` input 1: load request; accepted on a rising edge when `ser_ready`=1.
- `ser_ready` output 1: block can accept a word this cycle.
- `ser_out` output 1: current serial bit.
- `ser_bit_valid` output 1: `ser_out` carries a valid data bit this cycle.
- `ser_bit_index` output $clog2(WIDTH): position of the current bit in the word; counts 0..WIDTH-1 in transmit order.
- `ser_done` output 1: one-cycle pulse in the cycle after the last bit.

## Operation
- States:
  - IDLE: `ser_ready`=1, `ser_bit_valid`=0.
  - SHIFT: `ser_ready`=0, `ser_bit_valid`=1.
  - DONE: `ser_ready`=1, `ser_done`=1, `ser_bit_valid`=0.
- IDLE → SHIFT on an accepted `ser_load`.
  - Capture `ser_in` into the internal shift register.
  - Clear the bit counter.
- SHIFT:
  - `ser_out` = shift_reg[WIDTH-1] when MSB_FIRST=1, otherwise shift_reg[0].
  - Each cycle, shift toward the output end, filling with 0, and increment the counter.
  - SHIFT → DONE after the bit with index WIDTH-1 has been presented.
- DONE → SHIFT if `ser_load`=1: new word captured, counter cleared, no gap cycle.
- DONE → IDLE otherwise.
- `ser_load` while `ser_ready`=0 is ignored. No queuing, and the in-flight word is not disturbed.
- `ser_in` is sampled only at the accept edge; later changes have no effect on the word in flight.
- Outside SHIFT:
  - `ser_out`=0.
  - `ser_bit_index`=0.
- Counter and index never exceed WIDTH-1; no wrap-around is visible on the outputs.

## Timing
- Reset (`reset_n`=0, any time, asynchronous):
  - State = IDLE.
  - shift_reg = 0, counter = 0.
  - `ser_ready`=1, `ser_out`=0, `ser_bit_valid`=0, `ser_bit_index`=0, `ser_done`=0.
- Reset asserted mid-SHIFT aborts the word immediately; no `ser_done` is produced.
- Release of `reset_n` is synchronised externally; the first accept can occur on the first rising edge after release.
- Latency: load accepted at edge E0 → first bit valid in the cycle after E0.
- Bit k (k = 0..WIDTH-1) is valid in cycle E0+1+k.
- `ser_done`=1 in cycle E0+1+WIDTH.
- Throughput: one word every WIDTH+1 cycles under continuous `ser_load`.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then load 11'b01100110011 with MSB_FIRST=1 → `ser_out` sequence 0,1,1,0,0,1,1,0,0,1,1 with `ser_bit_valid`=1 for exactly 11 cycles and `ser_bit_index` 0..10; `ser_done` is high for exactly one cycle at E0+12, and `ser_ready` returns to 1 in that same cycle.
- Same word with MSB_FIRST=0 → `ser_out` sequence 1,1,0,0,1,1,0,0,1,1,0.
- Hold `ser_load`=1 continuously, loading 11'b11110111001 then 11'b00000111111 → second word's bit 0 appears in the cycle immediately after the first word's DONE cycle; 22 valid bits across 24 cycles; two `ser_done` pulses.
- Pulse `ser_load` with 11'b00100101101 during SHIFT, and change `ser_in` mid-word → in-flight word is transmitted unchanged, the new request is ignored, and the block returns to IDLE after DONE.
- Drive `reset_n`=0 for a fraction of a cycle (between clock edges) at bit 5 of 11'b11100000011 → all outputs go to their reset values before the next clock edge; no `ser_done`; a fresh load after release transmits its full 11 bits from index 0.
- Idle with `ser_load`=0 for 10 cycles after reset → `ser_ready`=1, `ser_bit_valid`=0, `ser_out`=0, `ser_done`=0 throughout.

Source files
------------

// File: rtl/register_serializer.sv
// Parallel-in/serial-out shifter: takes one WIDTH-bit word on a load handshake and
// presents it one bit per clock with a bit-valid strobe, index and end-of-word pulse.
module register_serializer #(
  parameter int WIDTH     = 11,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         ser_in,
  input  logic                     ser_load,
  output logic                     ser_ready,
  output logic                     ser_out,
  output logic                     ser_bit_valid,
  output logic [$clog2(WIDTH)-1:0] ser_bit_index,
  output logic                     ser_done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [IW-1:0]    cnt_reg;
  logic [WIDTH-1:0] shifted;

  // Bit sitting at the output end of a word for the configured direction.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign shifted = shift_once(shift_reg);

  // Outputs are computed one edge ahead so every port comes straight from a flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      ser_ready     <= 1'b1;
      ser_out       <= 1'b0;
      ser_bit_valid <= 1'b0;
      ser_bit_index <= '0;
      ser_done      <= 1'b0;
    end else begin
      ser_done <= 1'b0;
      case (state_reg)
        SHIFT: begin
          shift_reg <= shifted;
          if (cnt_reg == LAST_IDX) begin
            state_reg     <= DONE;
            cnt_reg       <= '0;
            ser_ready     <= 1'b1;
            ser_out       <= 1'b0;
            ser_bit_valid <= 1'b0;
            ser_bit_index <= '0;
            ser_done      <= 1'b1;
          end else begin
            cnt_reg       <= cnt_reg + IW'(1);
            ser_bit_index <= cnt_reg + IW'(1);
            ser_out       <= head_bit(shifted);
          end
        end
        default: begin
          // IDLE and DONE both accept a new word; DONE chains with no gap.
          if (ser_load) begin
            state_reg     <= SHIFT;
            shift_reg     <= ser_in;
            cnt_reg       <= '0;
            ser_ready     <= 1'b0;
            ser_out       <= head_bit(ser_in);
            ser_bit_valid <= 1'b1;
            ser_bit_index <= '0;
          end else begin
            state_reg     <= IDLE;
            ser_ready     <= 1'b1;
            ser_out       <= 1'b0;
            ser_bit_valid <= 1'b0;
            ser_bit_index <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_serializer.sv
// Scoreboard bench: one stimulus stream drives an MSB-first and an LSB-first instance;
// a word-level model queues the expected per-edge outputs and a monitor compares them.
module tb_register_serializer;
  localparam int W  = 11;
  localparam int IW = $clog2(W);

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [W-1:0]  ser_in = '0;
  logic          ser_load = 1'b0;

  logic          rdy_m, out_m, val_m, done_m;
  logic [IW-1:0] idx_m;
  logic          rdy_l, out_l, val_l, done_l;
  logic [IW-1:0] idx_l;

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset_n(reset_n), .ser_in(ser_in), .ser_load(ser_load),
    .ser_ready(rdy_m), .ser_out(out_m), .ser_bit_valid(val_m),
    .ser_bit_index(idx_m), .ser_done(done_m));

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset_n(reset_n), .ser_in(ser_in), .ser_load(ser_load),
    .ser_ready(rdy_l), .ser_out(out_l), .ser_bit_valid(val_l),
    .ser_bit_index(idx_l), .ser_done(done_l));

  always #5 clock = ~clock;

  typedef struct {
    int edge_no;
    bit is_done;
    bit b_msb;
    bit b_lsb;
    int idx;
  } item_t;

  item_t exp_q[$];
  int    edge_n      = 0;
  int    next_accept = 0;
  int    vectors     = 0;
  int    miscompares = 0;
  int    words       = 0;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, expv);
    end
  endtask

  // Word-level model: a word accepted at edge E shows bit k after edge E+k and
  // done after edge E+W; the next accept is possible at edge E+W+1.
  always @(posedge clock) begin
    edge_n++;
    if (reset_n && ser_load && edge_n >= next_accept) begin
      for (int k = 0; k < W; k++) begin
        item_t it;
        it.edge_no = edge_n + k;
        it.is_done = 1'b0;
        it.b_msb   = ser_in[W-1-k];
        it.b_lsb   = ser_in[k];
        it.idx     = k;
        exp_q.push_back(it);
      end
      begin
        item_t d;
        d.edge_no = edge_n + W;
        d.is_done = 1'b1;
        d.b_msb   = 1'b0;
        d.b_lsb   = 1'b0;
        d.idx     = 0;
        exp_q.push_back(d);
      end
      next_accept = edge_n + W + 1;
      words++;
      $display("edge %0d: word %0d accepted data=%b", edge_n, words, ser_in);
    end
  end

  // Reset discards whatever was in flight; a load may follow immediately.
  always @(negedge reset_n) begin
    exp_q.delete();
    next_accept = 0;
  end

  always @(negedge clock) begin
    bit e_valid, e_done, e_m, e_l;
    int e_idx;
    e_valid = 1'b0; e_done = 1'b0; e_m = 1'b0; e_l = 1'b0; e_idx = 0;
    while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
      chk("stale_expectation", exp_q[0].edge_no, edge_n);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].edge_no == edge_n) begin
      item_t it;
      it = exp_q.pop_front();
      if (it.is_done) e_done = 1'b1;
      else begin
        e_valid = 1'b1; e_m = it.b_msb; e_l = it.b_lsb; e_idx = it.idx;
      end
    end
    chk("msb_valid", int'(val_m), int'(e_valid));
    chk("msb_ready", int'(rdy_m), int'(!e_valid));
    chk("msb_done",  int'(done_m), int'(e_done));
    chk("msb_out",   int'(out_m), int'(e_m));
    chk("msb_index", int'(idx_m), e_idx);
    chk("lsb_valid", int'(val_l), int'(e_valid));
    chk("lsb_ready", int'(rdy_l), int'(!e_valid));
    chk("lsb_done",  int'(done_l), int'(e_done));
    chk("lsb_out",   int'(out_l), int'(e_l));
    chk("lsb_index", int'(idx_l), e_idx);
  end

  task automatic drive(input bit load, input logic [W-1:0] data);
    @(negedge clock);
    ser_load = load;
    ser_in   = data;
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, ser_in);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready_m"}, int'(rdy_m), 1);
    chk({tag, "_out_m"},   int'(out_m), 0);
    chk({tag, "_valid_m"}, int'(val_m), 0);
    chk({tag, "_index_m"}, int'(idx_m), 0);
    chk({tag, "_done_m"},  int'(done_m), 0);
    chk({tag, "_ready_l"}, int'(rdy_l), 1);
    chk({tag, "_valid_l"}, int'(val_l), 0);
    chk({tag, "_done_l"},  int'(done_l), 0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2 chk_reset_outputs("por");
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;

    // Idle after reset.
    idle(10);

    // Single word, both bit orders at once.
    drive(1'b1, 11'b01100110011);
    idle(14);

    // Back-to-back words under continuous load.
    drive(1'b1, 11'b11110111001);
    for (int k = 0; k < W + 1; k++) drive(1'b1, 11'b00000111111);
    idle(14);

    // Load request and data changes during SHIFT must not disturb the word.
    drive(1'b1, 11'b10110011100);
    for (int k = 0; k < W; k++)
      drive(k == 4, (k == 4) ? 11'b00100101101 : W'($urandom_range(0, (1 << W) - 1)));
    idle(4);

    // Short asynchronous reset while bit 5 is on the line.
    drive(1'b1, 11'b11100000011);
    idle(5);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    #1 reset_n = 1'b1;
    drive(1'b1, 11'b11100000011);
    idle(14);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      drive(($urandom % 3) == 0, W'($urandom_range(0, (1 << W) - 1)));
    idle(W + 4);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
